saturn_mem_xfer: RTL
====================

// Module: saturn_mem_xfer
// PURPOSE
//  Parametrised multi-nibble memory transfer engine for the Saturn core; replaces per-nibble DP_READ/DP_WRITE sequencing in the decoder.
//  Takes one register-field transfer request (address, direction, first/last nibble) and drives the hp48 bus command interface:
//  LOAD_DP, then one DP_READ/DP_WRITE per nibble. Assembles read data and reports completion/error.
//  Tracks the bus-side data pointer; skips LOAD_DP when the request address equals the already-loaded, auto-incremented pointer.
// PARAMETERS
//  ADDR_W   20  bus address width (nibble address)
//  NIBS     16  register width in nibbles (A/B/C/D = 16)
//  IDX_W    4   nibble index width, = $clog2(NIBS)
// PORTS
//  clk            in   1          core clock, all state on rising edge
//  reset          in   1          asynchronous, active-low; 0 forces all state to reset values
//  req_valid      in   1          transfer request
//  req_ready      out  1          engine idle, request accepted when req_valid & req_ready
//  req_write      in   1          1 = register->memory (DP_WRITE), 0 = memory->register (DP_READ)
//  req_addr       in   ADDR_W     start nibble address (D0/D1 value)
//  req_first      in   IDX_W      first register nibble index
//  req_last       in   IDX_W      last register nibble index
//  req_data       in   NIBS*4     source register, sampled at accept
//  dp_inval       in   1          invalidate pointer cache (core issued CONFIGURE/RESET/LOAD_PC)
//  bus_go         out  1          one-cycle pulse: bus_command/bus_address/bus_nibble_in valid
//  bus_command    out  4          BUSCMD_LOAD_DP / BUSCMD_DP_READ / BUSCMD_DP_WRITE, NOP otherwise
//  bus_address    out  ADDR_W     address for LOAD_DP
//  bus_nibble_in  out  4          write nibble for DP_WRITE
//  bus_ack        in   1          bus finished the last command (earliest cycle after bus_go)
//  bus_nibble_out in   4          read nibble, valid with bus_ack on DP_READ
//  bus_error      in   1          bus fault, sampled with bus_ack
//  done           out  1          one-cycle pulse at end of transfer
//  err            out  1          valid with done: transfer aborted by bus_error
//  rd_data        out  NIBS*4     read result; nibbles outside the field hold req_data values
// BEHAVIOUR
//  Reset: state IDLE, req_ready=1, bus_go=0, bus_command=NOP, bus_address=0, bus_nibble_in=0, done=0, err=0, rd_data=0, dp cache invalid.
//  Count: n = ((req_last - req_first) mod NIBS) + 1; first>last wraps modulo NIBS (e.g. first=14,last=1 -> nibbles 14,15,0,1, n=4).
//  FSM: IDLE -> (accept) LOAD or XFER_ISSUE -> XFER_WAIT -> ... -> DONE -> IDLE; any state -> ERR -> DONE on bus_error.
//   IDLE: req_ready=1. On accept latch write/addr/first/n/data; rd_data <= req_data.
//     Cache hit (cache valid & dp_cache==req_addr) -> XFER_ISSUE; else -> LOAD.
//   LOAD: pulse bus_go with LOAD_DP, bus_address=addr; wait bus_ack; then XFER_ISSUE.
//   XFER_ISSUE: pulse bus_go with DP_READ/DP_WRITE; on write bus_nibble_in=data[idx*4+:4].
//   XFER_WAIT: on bus_ack: read -> rd_data[idx*4+:4] <= bus_nibble_out; idx <= idx+1 mod NIBS; remaining--.
//     remaining reaches 0 -> DONE, else -> XFER_ISSUE.
//   DONE: done=1 one cycle, err as captured; dp_cache <= addr+n (mod 2^ADDR_W), valid unless err; -> IDLE.
//  Latency (ack one cycle after each go): miss = 2 + 2n + 1 cycles accept->done; hit = 2n + 1.
//  bus_go never asserts while a previous command is unacknowledged; req_ready=0 outside IDLE, requests then ignored.
//  bus_ack in IDLE/DONE: ignored. bus_error with ack: stop issuing, err=1, cache invalid, rd_data keeps nibbles received so far.
//  dp_inval: clears cache in any state; if same cycle as accept in IDLE, accept treats cache as invalid (LOAD issued).
//  Address wrap: dp_cache computed modulo 2^ADDR_W (0xFFFFE + 4 -> 0x00002).
//  Async reset mid-transfer: immediate return to reset values; outstanding bus command abandoned, cache invalid.
// STRUCTURE
//  BUSCMD_* codes come from bus_commands.v (shared); FSM state codes as localparams in a shared xfer-states include.
//  Natural sub-module: saturn_dp_cache (pointer register + valid bit + ADDR_W adder, compare-on-accept).
// TESTING
//  Read miss: addr=0x80000, first=0,last=4, memory 1,2,3,4,5 -> LOAD_DP 0x80000, 5 DP_READ, rd_data[19:0]=0x54321, done at cycle 13.
//  Write hit: repeat request at 0x80005 right after -> no LOAD_DP, 5 DP_WRITE of req_data nibbles, done after 11 cycles.
//  Wrap field: first=14,last=1 read -> 4 DP_READs into nibbles 14,15,0,1; nibbles 2..13 equal req_data.
//  Bus error on 3rd ack -> err=1 with done, 3rd nibble not written to rd_data, next request same addr issues LOAD_DP.
//  dp_inval between two contiguous requests -> second request issues LOAD_DP; address 0xFFFFE n=4 -> cache 0x00002.
//  Reset low mid-XFER_WAIT -> all outputs to reset values same cycle; req_valid ignored while busy (no extra bus_go).

Source files
------------

// File: rtl/saturn_mem_xfer_pkg.sv
// Shared bus command codes, engine states and field-length helper for the
// Saturn multi-nibble memory transfer engine.
package saturn_mem_xfer_pkg;

    localparam logic [3:0] BUSCMD_NOP      = 4'h0;
    localparam logic [3:0] BUSCMD_ID       = 4'h1;
    localparam logic [3:0] BUSCMD_PC_READ  = 4'h2;
    localparam logic [3:0] BUSCMD_DP_READ  = 4'h3;
    localparam logic [3:0] BUSCMD_PC_WRITE = 4'h4;
    localparam logic [3:0] BUSCMD_DP_WRITE = 4'h5;
    localparam logic [3:0] BUSCMD_LOAD_PC  = 4'h6;
    localparam logic [3:0] BUSCMD_LOAD_DP  = 4'h7;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_LOAD_WAIT,
        S_XFER_ISSUE,
        S_XFER_WAIT,
        S_ERR,
        S_DONE
    } xfer_state_t;

    // Nibbles covered by first..last, wrapping through the top of the register.
    function automatic int unsigned xfer_count(input int unsigned first,
                                               input int unsigned last,
                                               input int unsigned nibs);
        int unsigned span;
        span = last + nibs - first;
        if (span >= nibs) span = span - nibs;
        return span + 1;
    endfunction

endpackage

// File: rtl/saturn_mem_xfer_dp_cache.sv
// Mirror of the bus-side data pointer: lets a contiguous follow-up transfer
// skip its LOAD_DP.
module saturn_mem_xfer_dp_cache #(
    parameter int unsigned ADDR_W = 20,
    parameter int unsigned CNT_W  = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              inval,
    input  logic [ADDR_W-1:0] lookup_addr,
    output logic              hit,
    input  logic              update,
    input  logic              update_ok,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [CNT_W-1:0]  count
);

    logic [ADDR_W-1:0] ptr;
    logic              valid;

    // An invalidate in the lookup cycle must already force a miss.
    always_comb hit = valid && !inval && (ptr == lookup_addr);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ptr   <= '0;
            valid <= 1'b0;
        end else if (inval) begin
            valid <= 1'b0;
        end else if (update) begin
            ptr   <= base_addr + ADDR_W'(count);
            valid <= update_ok;
        end
    end

endmodule

// File: rtl/saturn_mem_xfer.sv
// Multi-nibble register<->memory transfer engine driving the hp48 bus command
// interface (LOAD_DP, then one DP_READ/DP_WRITE per nibble).
module saturn_mem_xfer
    import saturn_mem_xfer_pkg::*;
#(
    parameter int unsigned ADDR_W = 20,
    parameter int unsigned NIBS   = 16,
    parameter int unsigned IDX_W  = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [IDX_W-1:0]  req_first,
    input  logic [IDX_W-1:0]  req_last,
    input  logic [NIBS*4-1:0] req_data,
    input  logic              dp_inval,
    output logic              bus_go,
    output logic [3:0]        bus_command,
    output logic [ADDR_W-1:0] bus_address,
    output logic [3:0]        bus_nibble_in,
    input  logic              bus_ack,
    input  logic [3:0]        bus_nibble_out,
    input  logic              bus_error,
    output logic              done,
    output logic              err,
    output logic [NIBS*4-1:0] rd_data
);

    xfer_state_t       state, state_nx;
    logic              write_q;
    logic [ADDR_W-1:0] addr_q;
    logic [IDX_W-1:0]  idx_q;
    logic [IDX_W:0]    n_q;
    logic [IDX_W:0]    rem_q;
    logic [NIBS*4-1:0] data_q;
    logic              err_q;

    logic              accept;
    logic              cache_hit;
    logic              cache_update;
    logic              cache_ok;
    logic [IDX_W:0]    req_n;
    logic [IDX_W-1:0]  idx_nx;
    logic              nib_ack;

    always_comb begin
        req_ready    = (state == S_IDLE);
        accept       = req_valid && req_ready;
        req_n        = (IDX_W+1)'(xfer_count(32'(req_first), 32'(req_last), NIBS));
        idx_nx       = (idx_q == IDX_W'(NIBS - 1)) ? '0 : idx_q + 1'b1;
        nib_ack      = (state == S_XFER_WAIT) && bus_ack && !bus_error;
        cache_update = (state == S_DONE);
        cache_ok     = !err_q;
    end

    saturn_mem_xfer_dp_cache #(
        .ADDR_W (ADDR_W),
        .CNT_W  (IDX_W + 1)
    ) u_dp_cache (
        .clk         (clk),
        .reset       (reset),
        .inval       (dp_inval),
        .lookup_addr (req_addr),
        .hit         (cache_hit),
        .update      (cache_update),
        .update_ok   (cache_ok),
        .base_addr   (addr_q),
        .count       (n_q)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= S_IDLE;
        else        state <= state_nx;
    end

    // Bus outputs are Moore-decoded so a reset returns them to NOP immediately.
    always_comb begin
        state_nx      = state;
        bus_go        = 1'b0;
        bus_command   = BUSCMD_NOP;
        bus_address   = '0;
        bus_nibble_in = '0;
        done          = 1'b0;
        err           = 1'b0;
        case (state)
            S_IDLE: begin
                if (accept) state_nx = cache_hit ? S_XFER_ISSUE : S_LOAD;
            end
            S_LOAD: begin
                bus_go      = 1'b1;
                bus_command = BUSCMD_LOAD_DP;
                bus_address = addr_q;
                state_nx    = S_LOAD_WAIT;
            end
            S_LOAD_WAIT: begin
                if (bus_ack) state_nx = bus_error ? S_ERR : S_XFER_ISSUE;
            end
            S_XFER_ISSUE: begin
                bus_go      = 1'b1;
                bus_command = write_q ? BUSCMD_DP_WRITE : BUSCMD_DP_READ;
                if (write_q) bus_nibble_in = data_q[{idx_q, 2'b00} +: 4];
                state_nx    = S_XFER_WAIT;
            end
            S_XFER_WAIT: begin
                if (bus_ack) begin
                    if (bus_error)                          state_nx = S_ERR;
                    else if (rem_q == (IDX_W+1)'(1))        state_nx = S_DONE;
                    else                                    state_nx = S_XFER_ISSUE;
                end
            end
            S_ERR: begin
                state_nx = S_DONE;
            end
            S_DONE: begin
                done     = 1'b1;
                err      = err_q;
                state_nx = S_IDLE;
            end
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            write_q <= 1'b0;
            addr_q  <= '0;
            idx_q   <= '0;
            n_q     <= '0;
            rem_q   <= '0;
            data_q  <= '0;
            err_q   <= 1'b0;
            rd_data <= '0;
        end else begin
            if (accept) begin
                write_q <= req_write;
                addr_q  <= req_addr;
                idx_q   <= req_first;
                n_q     <= req_n;
                rem_q   <= req_n;
                data_q  <= req_data;
                err_q   <= 1'b0;
                rd_data <= req_data;
            end
            if (nib_ack) begin
                if (!write_q) rd_data[{idx_q, 2'b00} +: 4] <= bus_nibble_out;
                idx_q <= idx_nx;
                rem_q <= rem_q - 1'b1;
            end
            if ((state == S_XFER_WAIT || state == S_LOAD_WAIT) && bus_ack && bus_error)
                err_q <= 1'b1;
        end
    end

endmodule
